// File: rtl/interlaken_metaframe_sync_if.sv
// Word bus between the block decoder, the metaframe sync stage and lane deskew.
interface interlaken_metaframe_sync_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned HDR_W  = 2;

  logic [DATA_W-1:0] DATA_IN;
  logic [HDR_W-1:0]  HEADER_IN;
  logic              DATA_VALID;
  logic              BLOCK_LOCKED;
  logic [DATA_W-1:0] DATA_OUT;
  logic [HDR_W-1:0]  HEADER_OUT;
  logic              VALID_OUT;
  logic              FRAMING_OUT;
  logic              ALIGNED;
  logic              SYNC_ERR;
  logic              SCRAM_ERR;

  modport master (
    output DATA_IN, HEADER_IN, DATA_VALID, BLOCK_LOCKED,
    input  DATA_OUT, HEADER_OUT, VALID_OUT, FRAMING_OUT, ALIGNED, SYNC_ERR, SCRAM_ERR
  );

  modport slave (
    input  DATA_IN, HEADER_IN, DATA_VALID, BLOCK_LOCKED,
    output DATA_OUT, HEADER_OUT, VALID_OUT, FRAMING_OUT, ALIGNED, SYNC_ERR, SCRAM_ERR
  );
endinterface

// File: rtl/interlaken_metaframe_sync.sv
// Per-lane Interlaken metaframe delineation: Sync hunt/verify/lock, framing flagging.
// Define INTERLAKEN_DESCRAMBLE_EN to compile in the x^58+x^39+1 frame-synchronous descrambler.
module interlaken_metaframe_sync #(
  parameter int unsigned METAFRAME_LEN = 2048,
  parameter int unsigned SYNC_GOOD_CNT = 4,
  parameter int unsigned SYNC_BAD_CNT  = 4
) (
  input logic                        USER_CLK,
  input logic                        SYSTEM_RESET_N,
  interlaken_metaframe_sync_if.slave bus
);
  localparam int unsigned POS_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [63:0]      SYNC_WORD  = 64'h78F6_78F6_78F6_78F6;
  localparam logic [1:0]       HDR_CTRL   = 2'b10;
  localparam logic [5:0]       STATE_TYPE = 6'b001010;
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(METAFRAME_LEN - 1);
  localparam logic [CNT_W-1:0] GOOD_TGT   = CNT_W'(SYNC_GOOD_CNT);
  localparam logic [CNT_W-1:0] BAD_TGT    = CNT_W'(SYNC_BAD_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] bad_cnt;

  logic             is_sync;
  logic             is_state;
  logic [POS_W-1:0] pos_next;
  logic [CNT_W-1:0] good_inc;
  logic [CNT_W-1:0] bad_inc;
  logic [63:0]      data_fwd;
  logic             state_mismatch;

  // Word classification and saturating/wrapping counter increments.
  always_comb begin
    is_sync  = (bus.HEADER_IN == HDR_CTRL) && (bus.DATA_IN == SYNC_WORD);
    is_state = (bus.HEADER_IN == HDR_CTRL) && (bus.DATA_IN[63:58] == STATE_TYPE);
    pos_next = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    good_inc = (good_cnt == CNT_MAX) ? good_cnt : good_cnt + CNT_W'(1);
    bad_inc  = (bad_cnt == CNT_MAX) ? bad_cnt : bad_cnt + CNT_W'(1);
  end

`ifdef INTERLAKEN_DESCRAMBLE_EN
  logic [57:0] lfsr;
  logic [57:0] lfsr_adv;
  logic [63:0] plain;
  logic        fb;
  logic        frame_slot;

  // Slots 0/1 carry framing words: pass them raw and keep the LFSR still.
  always_comb begin
    frame_slot = (pos < POS_W'(2));
    lfsr_adv   = lfsr;
    plain      = bus.DATA_IN;
    fb         = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      fb       = lfsr_adv[57] ^ lfsr_adv[38];
      plain[i] = bus.DATA_IN[i] ^ fb;
      lfsr_adv = {lfsr_adv[56:0], fb};
    end
    data_fwd       = frame_slot ? bus.DATA_IN : plain;
    state_mismatch = (bus.DATA_IN[57:0] != lfsr);
  end

  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      lfsr <= '0;
    end else if (bus.BLOCK_LOCKED && bus.DATA_VALID) begin
      if (state != HUNT && pos == POS_W'(1) && is_state) begin
        lfsr <= bus.DATA_IN[57:0];
      end else if (!frame_slot) begin
        lfsr <= lfsr_adv;
      end
    end
  end
`else
  always_comb begin
    data_fwd       = bus.DATA_IN;
    state_mismatch = 1'b0;
  end
`endif

  // Framing FSM with registered forwarding path and error pulses.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state           <= HUNT;
      pos             <= '0;
      good_cnt        <= '0;
      bad_cnt         <= '0;
      bus.DATA_OUT    <= '0;
      bus.HEADER_OUT  <= '0;
      bus.VALID_OUT   <= 1'b0;
      bus.FRAMING_OUT <= 1'b0;
      bus.ALIGNED     <= 1'b0;
      bus.SYNC_ERR    <= 1'b0;
      bus.SCRAM_ERR   <= 1'b0;
    end else begin
      bus.SYNC_ERR  <= 1'b0;
      bus.SCRAM_ERR <= 1'b0;
      if (!bus.BLOCK_LOCKED) begin
        state           <= HUNT;
        pos             <= '0;
        good_cnt        <= '0;
        bad_cnt         <= '0;
        bus.VALID_OUT   <= 1'b0;
        bus.FRAMING_OUT <= 1'b0;
        bus.ALIGNED     <= 1'b0;
      end else if (bus.DATA_VALID) begin
        bus.DATA_OUT    <= data_fwd;
        bus.HEADER_OUT  <= bus.HEADER_IN;
        bus.VALID_OUT   <= (state == LOCKED);
        bus.FRAMING_OUT <= is_sync || is_state;
        pos             <= pos_next;
        case (state)
          HUNT: begin
            if (is_sync) begin
              state    <= VERIFY;
              pos      <= POS_W'(1);
              good_cnt <= CNT_W'(1);
            end else begin
              pos <= '0;
            end
          end
          VERIFY: begin
            if (pos == POS_W'(1) && !is_state) begin
              state    <= HUNT;
              pos      <= '0;
              good_cnt <= '0;
            end else if (pos == '0) begin
              if (is_sync) begin
                good_cnt <= good_inc;
                if (good_inc >= GOOD_TGT) begin
                  state       <= LOCKED;
                  bad_cnt     <= '0;
                  bus.ALIGNED <= 1'b1;
                end
              end else begin
                state    <= HUNT;
                pos      <= '0;
                good_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (pos == '0) begin
              if (is_sync) begin
                bad_cnt <= '0;
              end else begin
                bus.SYNC_ERR <= 1'b1;
                bad_cnt      <= bad_inc;
                if (bad_inc >= BAD_TGT) begin
                  state       <= HUNT;
                  pos         <= '0;
                  good_cnt    <= '0;
                  bus.ALIGNED <= 1'b0;
                end
              end
            end else if (pos == POS_W'(1) && (!is_state || state_mismatch)) begin
              bus.SCRAM_ERR <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end else begin
        bus.VALID_OUT   <= 1'b0;
        bus.FRAMING_OUT <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_interlaken_metaframe_sync.sv
// Directed bench for interlaken_metaframe_sync with METAFRAME_LEN=8 and a scoreboard
// of expected forwarded words.
module tb_interlaken_metaframe_sync;
  localparam int unsigned LEN = 8;
  localparam logic [63:0] SYNC = 64'h78F6_78F6_78F6_78F6;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  h;
    logic        fr;
    logic        se;
    logic        sce;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic [57:0] tx_lfsr = 58'h2AA_AAAA_AAAA_AAAA;
  logic [63:0] last_data = '0;

  interlaken_metaframe_sync_if bus ();

  interlaken_metaframe_sync #(
    .METAFRAME_LEN(LEN),
    .SYNC_GOOD_CNT(4),
    .SYNC_BAD_CNT (4)
  ) dut (
    .USER_CLK      (clk),
    .SYSTEM_RESET_N(rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word per rising edge; expected output queued when it should be forwarded.
  task automatic send(input logic [63:0] d, input logic [1:0] h, input bit out,
                      input logic [63:0] ed, input logic fr, input logic se, input logic sce);
    exp_t e;
    @(negedge clk);
    bus.DATA_IN    = d;
    bus.HEADER_IN  = h;
    bus.DATA_VALID = 1'b1;
    e.d = ed; e.h = h; e.fr = fr; e.se = se; e.sce = sce;
    if (out) q.push_back(e);
    last_data = ed;
    @(posedge clk);
    #1 bus.DATA_VALID = 1'b0;
  endtask

  task automatic tx_sync(input bit ok, input bit out, input logic se);
    logic [63:0] d;
    d = ok ? SYNC : (SYNC ^ 64'h1);
    send(d, 2'b10, out, d, ok, se, 1'b0);
  endtask

  task automatic tx_state(input bit ok, input bit out, input logic sce);
    logic [63:0] d;
    d = {(ok ? 6'b001010 : 6'b000000), tx_lfsr};
    send(d, 2'b10, out, d, ok, 1'b0, sce);
  endtask

  task automatic tx_data(input bit out);
    logic [63:0] p;
    logic [63:0] c;
    p = {$urandom(), $urandom()};
    c = p;
`ifdef INTERLAKEN_DESCRAMBLE_EN
    for (int i = 63; i >= 0; i--) begin
      logic s;
      s = tx_lfsr[57] ^ tx_lfsr[38];
      c[i] = p[i] ^ s;
      tx_lfsr = {tx_lfsr[56:0], s};
    end
`endif
    send(c, 2'b01, out, p, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tx_mf(input bit sync_ok, input bit sync_out, input logic se,
                       input bit rest_out, input bit state_ok, input logic sce);
    tx_sync(sync_ok, sync_out, se);
    tx_state(state_ok, rest_out, sce);
    for (int k = 0; k < int'(LEN) - 2; k++) tx_data(rest_out);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every forwarded word.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.VALID_OUT) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(bus.VALID_OUT), 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("data_out", bus.DATA_OUT, mon_e.d);
          chk("header_out", 64'(bus.HEADER_OUT), 64'(mon_e.h));
          chk("framing_out", 64'(bus.FRAMING_OUT), 64'(mon_e.fr));
          chk("sync_err", 64'(bus.SYNC_ERR), 64'(mon_e.se));
          chk("scram_err", 64'(bus.SCRAM_ERR), 64'(mon_e.sce));
        end
      end else begin
        chk("sync_err_idle", 64'(bus.SYNC_ERR), 64'd0);
        chk("scram_err_idle", 64'(bus.SCRAM_ERR), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DATA_IN      = '0;
    bus.HEADER_IN    = '0;
    bus.DATA_VALID   = 1'b0;
    bus.BLOCK_LOCKED = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data", bus.DATA_OUT, 64'd0);
    chk("rst_header", 64'(bus.HEADER_OUT), 64'd0);
    chk("rst_valid", 64'(bus.VALID_OUT), 64'd0);
    chk("rst_framing", 64'(bus.FRAMING_OUT), 64'd0);
    chk("rst_aligned", 64'(bus.ALIGNED), 64'd0);
    chk("rst_sync_err", 64'(bus.SYNC_ERR), 64'd0);
    chk("rst_scram_err", 64'(bus.SCRAM_ERR), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Clean stream: lock on the 4th Sync, first forwarded word is the State word.
    for (int m = 0; m < 3; m++) tx_mf(1, 0, 1'b0, 0, 1, 1'b0);
    chk("aligned_before_lock", 64'(bus.ALIGNED), 64'd0);
    tx_sync(1, 0, 1'b0);
    chk("aligned_at_lock", 64'(bus.ALIGNED), 64'd1);
    chk("lock_sync_not_out", 64'(bus.VALID_OUT), 64'd0);
    tx_state(1, 1, 1'b0);
    chk("first_out_valid", 64'(bus.VALID_OUT), 64'd1);
    chk("first_out_framing", 64'(bus.FRAMING_OUT), 64'd1);
    for (int k = 0; k < int'(LEN) - 2; k++) tx_data(1);

    // Three bad Syncs then a good one keep lock and clear the bad count.
    for (int m = 0; m < 3; m++) begin
      tx_sync(0, 1, 1'b1);
      chk("bad_sync_pulse", 64'(bus.SYNC_ERR), 64'd1);
      chk("bad_sync_aligned", 64'(bus.ALIGNED), 64'd1);
      tx_state(1, 1, 1'b0);
      for (int k = 0; k < int'(LEN) - 2; k++) tx_data(1);
    end
    tx_mf(1, 1, 1'b0, 1, 1, 1'b0);

    // Four consecutive bad Syncs: lock drops after the 4th, which is still forwarded.
    for (int m = 0; m < 3; m++) begin
      tx_mf(0, 1, 1'b1, 1, 1, 1'b0);
      chk("still_aligned", 64'(bus.ALIGNED), 64'd1);
    end
    tx_sync(0, 1, 1'b1);
    chk("lock_lost", 64'(bus.ALIGNED), 64'd0);
    tx_state(1, 0, 1'b0);
    for (int k = 0; k < int'(LEN) - 2; k++) tx_data(0);

    // Re-lock, then a State word with the wrong block type.
    for (int m = 0; m < 3; m++) tx_mf(1, 0, 1'b0, 0, 1, 1'b0);
    tx_sync(1, 0, 1'b0);
    chk("relock", 64'(bus.ALIGNED), 64'd1);
    tx_state(0, 1, 1'b1);
    chk("scram_err_pulse", 64'(bus.SCRAM_ERR), 64'd1);
    for (int k = 0; k < int'(LEN) - 2; k++) tx_data(1);
    tx_mf(1, 1, 1'b0, 1, 1, 1'b0);
    chk("aligned_after_scram_err", 64'(bus.ALIGNED), 64'd1);

    // DATA_VALID gap holds the output; then BLOCK_LOCKED drops for one cycle.
    tx_sync(1, 1, 1'b0);
    tx_state(1, 1, 1'b0);
    tx_data(1);
    tx_data(1);
    idle();
    chk("gap_valid", 64'(bus.VALID_OUT), 64'd0);
    chk("gap_hold", bus.DATA_OUT, last_data);
    tx_data(1);
    @(negedge clk);
    bus.BLOCK_LOCKED = 1'b0;
    @(posedge clk);
    #1 bus.BLOCK_LOCKED = 1'b1;
    chk("blk_unlock_aligned", 64'(bus.ALIGNED), 64'd0);
    for (int k = 0; k < 3; k++) tx_data(0);
    for (int m = 0; m < 3; m++) tx_mf(1, 0, 1'b0, 0, 1, 1'b0);
    chk("blk_relock_pending", 64'(bus.ALIGNED), 64'd0);
    tx_sync(1, 0, 1'b0);
    chk("blk_relock", 64'(bus.ALIGNED), 64'd1);
    tx_state(1, 1, 1'b0);
    for (int k = 0; k < int'(LEN) - 2; k++) tx_data(1);

    // Asynchronous reset mid-metaframe.
    tx_sync(1, 1, 1'b0);
    tx_state(1, 1, 1'b0);
    tx_data(1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_aligned", 64'(bus.ALIGNED), 64'd0);
    chk("async_rst_valid", 64'(bus.VALID_OUT), 64'd0);
    chk("async_rst_data", bus.DATA_OUT, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sync at word 5, corrupt Sync one metaframe later: back to HUNT.
    for (int k = 0; k < 4; k++) tx_data(0);
    tx_sync(1, 0, 1'b0);
    tx_state(1, 0, 1'b0);
    for (int k = 0; k < int'(LEN) - 2; k++) tx_data(0);
    tx_sync(0, 0, 1'b0);
    chk("corrupt_verify_aligned", 64'(bus.ALIGNED), 64'd0);
    for (int m = 0; m < 3; m++) tx_mf(1, 0, 1'b0, 0, 1, 1'b0);
    chk("hunt_needs_four", 64'(bus.ALIGNED), 64'd0);
    tx_sync(1, 0, 1'b0);
    chk("final_lock", 64'(bus.ALIGNED), 64'd1);
    tx_state(1, 1, 1'b0);
    tx_data(1);
    tx_data(1);
    idle();
    idle();
    chk("scoreboard_drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/interlaken_metaframe_sync.md
# interlaken_metaframe_sync

Per-lane Interlaken metaframe delineation stage, directly downstream of the 64B/67B block decoder. It consumes decoded 64-bit words with their 2-bit sync headers and the decoder's block-lock indication. It then hunts for the metaframe Sync word and verifies metaframe periodicity and Scrambler State words. Once locked, it forwards words to the lane deskew logic with framing-layer words flagged.

## Interface
- METAFRAME_LEN, 2048, words per metaframe including framing words; legal range 4..65535
- SYNC_GOOD_CNT, 4, consecutive correctly placed Sync words required to declare lock (includes the first one found)
- SYNC_BAD_CNT, 4, consecutive missing or corrupt Sync words that drop lock
- USER_CLK  in  1  sole clock; all logic rising-edge
- SYSTEM_RESET_N  in  1  asynchronous, active-low reset
- DATA_IN  in  64  decoded word from the block decoder, already inversion-corrected
- HEADER_IN  in  2  sync header; 2'b01 means data, 2'b10 means control
- DATA_VALID  in  1  DATA_IN/HEADER_IN carry a word this cycle
- BLOCK_LOCKED  in  1  decoder block lock
- DATA_OUT  out  64  forwarded word (descrambled when configured)
- HEADER_OUT  out  2  forwarded header
- VALID_OUT  out  1  word valid and lane aligned
- FRAMING_OUT  out  1  the forwarded word is a Sync or Scrambler State word
- ALIGNED  out  1  state == LOCKED
- SYNC_ERR  out  1  single-cycle pulse: bad Sync word while LOCKED
- SCRAM_ERR  out  1  single-cycle pulse: bad Scrambler State word while LOCKED

## Operation
- Sync word: header 2'b10 and data 64'h78F6_78F6_78F6_78F6. Scrambler State word: header 2'b10 and data[63:58] = 6'b001010, with data[57:0] carrying the state.
- Position counter `pos` runs 0..METAFRAME_LEN-1, advances only on DATA_VALID, and wraps to 0. Sync is expected at pos 0 and Scrambler State at pos 1.
- FSM states are HUNT, VERIFY and LOCKED.
- HUNT: on a valid Sync word, go to VERIFY with pos←1 and good_cnt←1. Otherwise stay in HUNT with pos held at 0.
- VERIFY at pos 1: a non-State word sends the FSM to HUNT.
- VERIFY at pos 0: a Sync word increments good_cnt. When good_cnt reaches SYNC_GOOD_CNT, go to LOCKED with bad_cnt←0. A non-Sync word sends the FSM to HUNT.
- LOCKED at pos 0: a Sync word clears bad_cnt. A non-Sync word pulses SYNC_ERR and increments bad_cnt. At the SYNC_BAD_CNT-th consecutive bad word, go to HUNT. pos keeps running in either case.
- LOCKED at pos 1: a non-State word pulses SCRAM_ERR with no state change.
- BLOCK_LOCKED low forces HUNT on the next edge: pos, good_cnt and bad_cnt are cleared, and no error pulses are generated. This has priority over all transitions.
- DATA_VALID low: nothing advances, VALID_OUT=0, and the previous DATA_OUT is held.
- VALID_OUT is decided by the state before the current word's transition. The Sync word that completes lock is not output. The Sync word that loses lock is output, with SYNC_ERR.
- Counter widths: pos is 16 bits; good_cnt and bad_cnt are 4 bits and saturate.

## Timing
- Reset values: DATA_OUT=0, HEADER_OUT=0, VALID_OUT=0, FRAMING_OUT=0, ALIGNED=0, SYNC_ERR=0, SCRAM_ERR=0. FSM is in HUNT with all counters 0.
- Latency is fixed at 1 cycle from input word to DATA_OUT/HEADER_OUT/VALID_OUT/FRAMING_OUT. Error pulses align with their offending word on the output.
- ALIGNED rises in the cycle after the lock-completing Sync word is sampled, and falls in the cycle after the SYNC_BAD_CNT-th bad word or a low BLOCK_LOCKED.
- Reset asserted mid-metaframe takes effect immediately (asynchronous). Operation restarts in HUNT after deassertion.

## Configuration
- INTERLAKEN_DESCRAMBLE_EN defined: a 58-bit frame-synchronous descrambler is compiled in.
  - Polynomial is x^58+x^39+1.
  - Loading: a valid Scrambler State word at pos 1 loads the LFSR with data[57:0].
  - Per non-framing data bit, processed from bit 63 down to 0: s=lfsr[57]^lfsr[38], out=in^s, lfsr={lfsr[56:0],s}.
  - Framing words pass unmodified and do not advance the LFSR.
  - SCRAM_ERR additionally pulses in LOCKED when a received state differs from the LFSR's running value.
- Not defined: no LFSR is compiled in, DATA_OUT equals the registered DATA_IN, and SCRAM_ERR reports block-type errors only.

## Test plan
- METAFRAME_LEN=8, clean framed stream: ALIGNED rises 1 cycle after the 4th Sync word. The first VALID_OUT word is the State word, with FRAMING_OUT=1.
- Random data until a Sync at word 5, then a corrupt Sync 8 words later: the FSM returns to HUNT and ALIGNED stays 0.
- Locked, then 3 bad Syncs followed by a good one: three SYNC_ERR pulses, ALIGNED stays 1, and bad_cnt clears. Four consecutive bad Syncs: ALIGNED drops after the 4th.
- Locked with a State word whose data[63:58]=6'b000000: one SCRAM_ERR pulse at pos 1 and no loss of lock.
- BLOCK_LOCKED deasserted for 1 cycle mid-metaframe: ALIGNED=0 the next cycle. Re-lock needs 4 new Syncs.
- With INTERLAKEN_DESCRAMBLE_EN, feeding words scrambled from seed 58'h2AA_AAAA_AAAA_AAAA: DATA_OUT equals the original plaintext for every data word and SCRAM_ERR stays 0.
